// File: rtl/song_player.sv
// song_player: steps a song ROM one slot per tick, converts each note number
// into a half-period and drives a square-wave tone output.
module song_player #(
  parameter int unsigned TICK_DIV = 12_500_000,
  parameter int unsigned SONG_LEN = 365,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play,
  input  logic              restart,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [9:0]        rom_note,
  output logic [9:0]        cur_note,
  output logic              note_valid,
  output logic              tone,
  output logic              done
);

  localparam int unsigned NOTE_W = 10;
  localparam int unsigned HALF_W = 21;
  localparam int unsigned REM_W  = 7;
  localparam int unsigned OCT_W  = 3;
  localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);
  localparam logic [NOTE_W-1:0] NOTE_MAX  = NOTE_W'(88);
  localparam logic [REM_W-1:0]  SEMIS     = REM_W'(12);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_CONV,
    S_SOUND
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  slot_cnt;
  logic [REM_W-1:0]  rem;
  logic [OCT_W-1:0]  oct;
  logic [NOTE_W-1:0] note_lat;
  logic [HALF_W-1:0] half;
  logic [HALF_W-1:0] tone_cnt;

  logic run_c, tick_c, gen_on_c;
  logic start_c, latch_c, step_c, load_c, adv_c, fin_c;

  // Half-period of the lowest octave (A0..G#1) in clk cycles at 100 MHz.
  function automatic logic [HALF_W-1:0] base_half(input logic [3:0] semi);
    case (semi)
      4'd0:    base_half = HALF_W'(1818182);
      4'd1:    base_half = HALF_W'(1716135);
      4'd2:    base_half = HALF_W'(1619816);
      4'd3:    base_half = HALF_W'(1528903);
      4'd4:    base_half = HALF_W'(1443092);
      4'd5:    base_half = HALF_W'(1362097);
      4'd6:    base_half = HALF_W'(1285649);
      4'd7:    base_half = HALF_W'(1213491);
      4'd8:    base_half = HALF_W'(1145383);
      4'd9:    base_half = HALF_W'(1081097);
      4'd10:   base_half = HALF_W'(1020420);
      4'd11:   base_half = HALF_W'(963148);
      default: base_half = '0;
    endcase
  endfunction

  assign run_c    = play && !done;
  assign tick_c   = run_c && (slot_cnt == TICK_LAST);
  assign gen_on_c = (state_q != S_IDLE) && play && (half != '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and datapath strobes; restart overrides everything.
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    latch_c = 1'b0;
    step_c  = 1'b0;
    load_c  = 1'b0;
    adv_c   = 1'b0;
    fin_c   = 1'b0;
    if (restart) begin
      state_d = play ? S_FETCH : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (play && !done) begin
            state_d = S_FETCH;
            start_c = 1'b1;
          end
        end
        S_FETCH: begin
          if (play) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (play) begin
            state_d = S_CONV;
            latch_c = 1'b1;
          end
        end
        S_CONV: begin
          if (play) begin
            if (rem >= SEMIS) begin
              step_c = 1'b1;
            end else begin
              load_c  = 1'b1;
              state_d = S_SOUND;
            end
          end
        end
        S_SOUND: begin
          if (tick_c) begin
            if (rom_addr == ADDR_LAST) begin
              fin_c   = 1'b1;
              state_d = S_IDLE;
            end else begin
              adv_c   = 1'b1;
              state_d = S_FETCH;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Slot timer: free-runs while playing, rewinds on start or restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
    end else if (restart || start_c) begin
      slot_cnt <= '0;
    end else if (run_c) begin
      slot_cnt <= tick_c ? '0 : slot_cnt + CNT_W'(1);
    end
  end

  // Song position and end-of-song flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      done     <= 1'b0;
    end else if (restart) begin
      rom_addr <= '0;
      done     <= 1'b0;
    end else if (fin_c) begin
      rom_addr <= '0;
      done     <= 1'b1;
    end else if (adv_c) begin
      rom_addr <= rom_addr + ADDR_W'(1);
    end
  end

  // Note decomposition: rests skip the divide, others subtract 12 per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      oct      <= '0;
      note_lat <= '0;
    end else if (latch_c) begin
      oct <= '0;
      if ((rom_note == '0) || (rom_note > NOTE_MAX)) begin
        rem      <= '0;
        note_lat <= '0;
      end else begin
        rem      <= REM_W'(rom_note - NOTE_W'(1));
        note_lat <= rom_note;
      end
    end else if (step_c) begin
      rem <= rem - SEMIS;
      oct <= oct + OCT_W'(1);
    end
  end

  // Publish the converted note and its half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_note   <= '0;
      half       <= '0;
      note_valid <= 1'b0;
    end else if (restart) begin
      cur_note   <= '0;
      half       <= '0;
      note_valid <= 1'b0;
    end else begin
      note_valid <= load_c;
      if (load_c) begin
        cur_note <= note_lat;
        half     <= (note_lat == '0) ? '0 : (base_half(rem[3:0]) >> oct);
      end
    end
  end

  // Square-wave generator; a repeated note keeps its phase across slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt <= '0;
      tone     <= 1'b0;
    end else if (restart || fin_c || !gen_on_c ||
                 (load_c && (note_lat != cur_note))) begin
      tone_cnt <= '0;
      tone     <= 1'b0;
    end else if (tone_cnt == half - HALF_W'(1)) begin
      tone_cnt <= '0;
      tone     <= ~tone;
    end else begin
      tone_cnt <= tone_cnt + HALF_W'(1);
    end
  end

endmodule
